// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// Package : seg7_pkg
// Shared 7-segment definitions: blank code, active-low decode table, settle
// FSM state codes and the pattern -> digit lookup helper.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seg7_pkg;

   // All segments off (active-low bus).
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} codes, indexed by hex digit value.
   localparam logic [6:0] SEG_CODE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // Settle FSM states.
   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_SETTLE = 1'b1;

   typedef struct packed {
      logic       legal;
      logic [3:0] digit;
   } seg7_lookup_t;

   // Reverse lookup of a segment pattern; legal=0 when the pattern is not a digit.
   function automatic seg7_lookup_t seg7_lookup(input logic [6:0] pattern);
      seg7_lookup_t res;
      res.legal = 1'b0;
      res.digit = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (pattern == SEG_CODE[i]) begin
            res.legal = 1'b1;
            res.digit = 4'(i);
         end
      end
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_pattern_decoder_if.sv
// ---------------------------------------------------------------------------
// Interface : seg7_pattern_decoder_if
// Segment input bus, digit valid/ready handshake and status flags.
// Optional macro SEG7_ERR_COUNT_EN adds the err_count status field.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface seg7_pattern_decoder_if;
   logic [6:0] seg_in;
   logic       seg_strobe;
   logic [3:0] digit;
   logic       digit_valid;
   logic       digit_ready;
   logic       blank;
   logic       pattern_err;
   logic       overrun;
   logic [6:0] err_pattern;
   logic       clr_flags;
`ifdef SEG7_ERR_COUNT_EN
   logic [7:0] err_count;

   modport slave  (input  seg_in, seg_strobe, digit_ready, clr_flags,
                   output digit, digit_valid, blank, pattern_err, overrun, err_pattern, err_count);
   modport master (output seg_in, seg_strobe, digit_ready, clr_flags,
                   input  digit, digit_valid, blank, pattern_err, overrun, err_pattern, err_count);
`else
   modport slave  (input  seg_in, seg_strobe, digit_ready, clr_flags,
                   output digit, digit_valid, blank, pattern_err, overrun, err_pattern);
   modport master (output seg_in, seg_strobe, digit_ready, clr_flags,
                   input  digit, digit_valid, blank, pattern_err, overrun, err_pattern);
`endif
endinterface

`default_nettype wire

// File: rtl/seg7_settle_filter.sv
// ---------------------------------------------------------------------------
// Module : seg7_settle_filter
// Debounces strobed segment samples: a pattern different from the last locked
// one must be seen on STABLE_CYCLES consecutive strobes before it is accepted.
// Emits a single-cycle accept pulse together with the accepted pattern.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg7_settle_filter
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic [6:0] seg_in,
   input  wire logic       seg_strobe,
   output logic            accept,
   output logic [6:0]      accept_pattern
);

   localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic [0:0]       state_q, state_d;
   logic [6:0]       cand_q, cand_d;
   logic [6:0]       locked_q, locked_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;

   assign cnt_inc = cnt_q + CNT_ONE;

   // Next-state: track candidate pattern, count matching strobes, fire accept.
   always_comb begin
      state_d        = state_q;
      cand_d         = cand_q;
      locked_d       = locked_q;
      cnt_d          = cnt_q;
      accept         = 1'b0;
      accept_pattern = cand_q;
      if (seg_strobe) begin
         if (state_q == S_IDLE) begin
            if (seg_in != locked_q) begin
               cand_d = seg_in;
               cnt_d  = CNT_ONE;
               if (STABLE_CYCLES == 1) begin
                  // A single sample is enough: accept without visiting SETTLE.
                  accept         = 1'b1;
                  accept_pattern = seg_in;
                  locked_d       = seg_in;
                  cnt_d          = '0;
               end else begin
                  state_d = S_SETTLE;
               end
            end
         end else begin
            if (seg_in == cand_q) begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_TARGET) begin
                  accept   = 1'b1;
                  locked_d = cand_q;
                  cnt_d    = '0;
                  state_d  = S_IDLE;
               end
            end else if (seg_in == locked_q) begin
               // Bus bounced back to the settled value: abandon the candidate.
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cand_d = seg_in;
               cnt_d  = CNT_ONE;
            end
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cand_q   <= SEG_BLANK;
         locked_q <= SEG_BLANK;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         cand_q   <= cand_d;
         locked_q <= locked_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/seg7_pattern_decoder.sv
// ---------------------------------------------------------------------------
// Module : seg7_pattern_decoder
// Recovers hex digits from a debounced active-low 7-segment bus, delivers
// each new digit once over valid/ready and flags illegal patterns/overruns.
// Optional macro SEG7_ERR_COUNT_EN adds a saturating illegal-pattern counter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg7_pattern_decoder
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
   input  wire logic            clk,
   input  wire logic            rst,
   seg7_pattern_decoder_if.slave bus
);

   logic         accept;
   logic [6:0]   accept_pattern;
   seg7_lookup_t lk;

   logic [3:0] digit_q, digit_d;
   logic       digit_valid_q, digit_valid_d;
   logic       blank_q, blank_d;
   logic       pattern_err_q, pattern_err_d;
   logic       overrun_q, overrun_d;
   logic [6:0] err_pattern_q, err_pattern_d;

   seg7_settle_filter #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
   ) u_filter (
      .clk            (clk),
      .rst            (rst),
      .seg_in         (bus.seg_in),
      .seg_strobe     (bus.seg_strobe),
      .accept         (accept),
      .accept_pattern (accept_pattern)
   );

   assign lk = seg7_lookup(accept_pattern);

   // Handshake register and flags; clears are applied first so set events win.
   always_comb begin
      digit_d       = digit_q;
      digit_valid_d = digit_valid_q;
      blank_d       = blank_q;
      pattern_err_d = pattern_err_q;
      overrun_d     = overrun_q;
      err_pattern_d = err_pattern_q;
      if (digit_valid_q && bus.digit_ready) begin
         digit_valid_d = 1'b0;
      end
      if (bus.clr_flags) begin
         pattern_err_d = 1'b0;
         overrun_d     = 1'b0;
      end
      if (accept) begin
         if (accept_pattern == SEG_BLANK) begin
            blank_d = 1'b1;
         end else if (lk.legal) begin
            if (!digit_valid_q || bus.digit_ready) begin
               digit_d       = lk.digit;
               digit_valid_d = 1'b1;
               blank_d       = 1'b0;
            end else begin
               // Consumer still holds the previous digit: keep it, drop the new one.
               overrun_d = 1'b1;
            end
         end else begin
            pattern_err_d = 1'b1;
            err_pattern_d = accept_pattern;
         end
      end
   end

   // Output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         digit_q       <= 4'h0;
         digit_valid_q <= 1'b0;
         blank_q       <= 1'b1;
         pattern_err_q <= 1'b0;
         overrun_q     <= 1'b0;
         err_pattern_q <= SEG_BLANK;
      end else begin
         digit_q       <= digit_d;
         digit_valid_q <= digit_valid_d;
         blank_q       <= blank_d;
         pattern_err_q <= pattern_err_d;
         overrun_q     <= overrun_d;
         err_pattern_q <= err_pattern_d;
      end
   end

   assign bus.digit       = digit_q;
   assign bus.digit_valid = digit_valid_q;
   assign bus.blank       = blank_q;
   assign bus.pattern_err = pattern_err_q;
   assign bus.overrun     = overrun_q;
   assign bus.err_pattern = err_pattern_q;

`ifdef SEG7_ERR_COUNT_EN
   logic [7:0] err_count_q, err_count_d;

   // Saturating count of illegal accepts; an increment on the clear cycle yields 1.
   always_comb begin
      err_count_d = bus.clr_flags ? 8'h00 : err_count_q;
      if (accept && (accept_pattern != SEG_BLANK) && !lk.legal && (err_count_d != 8'hFF)) begin
         err_count_d = err_count_d + 8'h01;
      end
   end

   // Error counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_count_q <= 8'h00;
      end else begin
         err_count_q <= err_count_d;
      end
   end

   assign bus.err_count = err_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seg7_pattern_decoder.sv
// ---------------------------------------------------------------------------
// Testbench : tb_seg7_pattern_decoder
// Directed vector table, hand-written corner sequences and randomized traffic
// checked every cycle against a run-length reference model of the decoder.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seg7_pattern_decoder;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seg7_pattern_decoder_if bus();

   seg7_pattern_decoder #(.STABLE_CYCLES(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [6:0] codes [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // Reference model state: settled pattern plus length of the current run of
   // identical strobed samples.
   logic [3:0] m_digit;
   logic       m_valid, m_blank, m_perr, m_ovr;
   logic [6:0] m_errpat, m_locked, m_run_val;
   logic [7:0] m_errcnt;
   int         m_run_len;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic model_step(input logic [6:0] seg, input logic stb, input logic rdy,
                             input logic clr, input logic r);
      logic       acc, leg, old_valid;
      logic [3:0] val;
      if (r) begin
         m_digit = 4'h0; m_valid = 1'b0; m_blank = 1'b1; m_perr = 1'b0; m_ovr = 1'b0;
         m_errpat = 7'h7F; m_errcnt = 8'h00; m_locked = 7'h7F; m_run_val = 7'h7F;
         m_run_len = 0;
         return;
      end
      acc = 1'b0;
      if (stb) begin
         if (m_run_len > 0 && seg == m_run_val) m_run_len++;
         else begin
            m_run_val = seg;
            m_run_len = 1;
         end
         if (m_run_len == N && m_run_val != m_locked) begin
            acc      = 1'b1;
            m_locked = m_run_val;
         end
      end
      old_valid = m_valid;
      if (m_valid && rdy) m_valid = 1'b0;
      if (clr) begin
         m_perr = 1'b0; m_ovr = 1'b0; m_errcnt = 8'h00;
      end
      if (acc) begin
         leg = 1'b0;
         val = 4'h0;
         for (int k = 0; k < 16; k++)
            if (codes[k] == m_run_val) begin
               leg = 1'b1;
               val = 4'(k);
            end
         if (m_run_val == 7'h7F) m_blank = 1'b1;
         else if (leg) begin
            if (!old_valid || rdy) begin
               m_digit = val; m_valid = 1'b1; m_blank = 1'b0;
            end else m_ovr = 1'b1;
         end else begin
            m_perr   = 1'b1;
            m_errpat = m_run_val;
            if (m_errcnt != 8'hFF) m_errcnt = m_errcnt + 8'h01;
         end
      end
   endtask

   task automatic compare_all();
      chk("digit",       {4'h0, bus.digit},       {4'h0, m_digit});
      chk("digit_valid", {7'h0, bus.digit_valid}, {7'h0, m_valid});
      chk("blank",       {7'h0, bus.blank},       {7'h0, m_blank});
      chk("pattern_err", {7'h0, bus.pattern_err}, {7'h0, m_perr});
      chk("overrun",     {7'h0, bus.overrun},     {7'h0, m_ovr});
      chk("err_pattern", {1'b0, bus.err_pattern}, {1'b0, m_errpat});
`ifdef SEG7_ERR_COUNT_EN
      chk("err_count",   bus.err_count,           m_errcnt);
`endif
   endtask

   // One clock: drive inputs, advance model, sample #1 after the edge, compare.
   task automatic cyc(input logic [6:0] seg, input logic stb, input logic rdy,
                      input logic clr, input logic r);
      bus.seg_in      = seg;
      bus.seg_strobe  = stb;
      bus.digit_ready = rdy;
      bus.clr_flags   = clr;
      rst             = r;
      model_step(seg, stb, rdy, clr, r);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic settle(input logic [6:0] seg, input logic rdy, input int n);
      for (int i = 0; i < n; i++) cyc(seg, 1'b1, rdy, 1'b0, 1'b0);
   endtask

   typedef struct {
      logic [6:0] seg;
      logic       stb;
      logic       rdy;
      logic [3:0] d;
      logic       v;
      logic       b;
   } vec_t;

   vec_t tbl [12];

   initial begin
      logic [6:0] cur;
      int         hold;
      int         sel;

      tbl[0]  = '{7'h24, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1};
      tbl[1]  = '{7'h24, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1};
      tbl[2]  = '{7'h24, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1};
      tbl[3]  = '{7'h24, 1'b1, 1'b1, 4'h2, 1'b1, 1'b0};
      tbl[4]  = '{7'h24, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0};
      tbl[5]  = '{7'h24, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0};
      tbl[6]  = '{7'h30, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0};
      tbl[7]  = '{7'h30, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0};
      tbl[8]  = '{7'h30, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0};
      tbl[9]  = '{7'h30, 1'b1, 1'b1, 4'h3, 1'b1, 1'b0};
      tbl[10] = '{7'h00, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0};
      tbl[11] = '{7'h00, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0};

      // Reset state.
      cyc(7'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(7'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst_blank", {7'h0, bus.blank}, 8'h01);
      chk("rst_errpat", {1'b0, bus.err_pattern}, 8'h7F);

      // Table: digit 2 single-cycle valid, then restarted settle yields only 3.
      for (int i = 0; i < 12; i++) begin
         cyc(tbl[i].seg, tbl[i].stb, tbl[i].rdy, 1'b0, 1'b0);
         chk($sformatf("tbl%0d_digit", i), {4'h0, bus.digit}, {4'h0, tbl[i].d});
         chk($sformatf("tbl%0d_valid", i), {7'h0, bus.digit_valid}, {7'h0, tbl[i].v});
         chk($sformatf("tbl%0d_blank", i), {7'h0, bus.blank}, {7'h0, tbl[i].b});
      end

      // Overrun: 4 held while 5 settles; 5 is dropped.
      settle(7'h19, 1'b0, N);
      chk("ovr_d4", {4'h0, bus.digit}, 8'h04);
      settle(7'h12, 1'b0, N);
      chk("ovr_flag", {7'h0, bus.overrun}, 8'h01);
      chk("ovr_keep4", {4'h0, bus.digit}, 8'h04);
      cyc(7'h12, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("ovr_consumed", {7'h0, bus.digit_valid}, 8'h00);
      for (int i = 0; i < 3; i++) cyc(7'h12, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("ovr_no5", {7'h0, bus.digit_valid}, 8'h00);
      cyc(7'h12, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("ovr_clr", {7'h0, bus.overrun}, 8'h00);

      // Blank then illegal pattern.
      settle(7'h7F, 1'b1, N);
      chk("blank_set", {7'h0, bus.blank}, 8'h01);
      chk("blank_novalid", {7'h0, bus.digit_valid}, 8'h00);
      settle(7'h55, 1'b1, N);
      chk("illegal_err", {7'h0, bus.pattern_err}, 8'h01);
      chk("illegal_pat", {1'b0, bus.err_pattern}, 8'h55);

      // Accept coincides with consumption of the held digit.
      settle(7'h03, 1'b0, N);
      chk("co_db", {4'h0, bus.digit}, 8'h0B);
      settle(7'h08, 1'b0, N - 1);
      cyc(7'h08, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("co_da", {4'h0, bus.digit}, 8'h0A);
      chk("co_valid", {7'h0, bus.digit_valid}, 8'h01);
      chk("co_noovr", {7'h0, bus.overrun}, 8'h00);
      cyc(7'h08, 1'b0, 1'b1, 1'b0, 1'b0);

      // Reset mid-settle discards the pending pattern.
      settle(7'h00, 1'b1, 2);
      cyc(7'h00, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("mid_rst_valid", {7'h0, bus.digit_valid}, 8'h00);
      chk("mid_rst_perr", {7'h0, bus.pattern_err}, 8'h00);
      settle(7'h00, 1'b1, 2);
      chk("mid_rst_noout", {7'h0, bus.digit_valid}, 8'h00);
      chk("mid_rst_digit", {4'h0, bus.digit}, 8'h00);

      // Randomized traffic.
      hold = 0;
      cur  = 7'h7F;
      for (int i = 0; i < 2500; i++) begin
         if (hold == 0) begin
            sel = int'($urandom_range(0, 11));
            if (sel < 8)       cur = codes[$urandom_range(0, 15)];
            else if (sel == 8) cur = 7'h7F;
            else if (sel == 9) cur = 7'h55;
            else if (sel == 10) cur = 7'($urandom_range(0, 127));
            hold = int'($urandom_range(1, 7));
         end
         if ($urandom_range(0, 3) != 0) begin
            hold--;
            cyc(cur, 1'b1, ($urandom_range(0, 1) == 1), ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 149) == 0));
         end else begin
            cyc(cur, 1'b0, ($urandom_range(0, 1) == 1), ($urandom_range(0, 19) == 0), 1'b0);
         end
      end

`ifdef SEG7_ERR_COUNT_EN
      // Saturation of the illegal-pattern counter, then clear.
      cyc(7'h7F, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 300; i++) settle((i % 2 == 0) ? 7'h55 : 7'h56, 1'b1, N);
      chk("errcnt_sat", bus.err_count, 8'hFF);
      cyc(7'h56, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("errcnt_clr", bus.err_count, 8'h00);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
